instruction_fetch_unit: RTL and testbench

- Front end of the single-issue RISC-V pipeline. Owns the program counter and drives the combinational instruction memory's byte address. Captures the returned word into the IF/ID pipeline register for the decode stage.
- Handles pipeline stalls, taken-branch redirects with squash of the wrong-path fetch, and halting fetch at the end of the populated instruction memory.

---
 rtl/instruction_fetch_unit.sv | 98 +++++++++
 tb/tb_instruction_fetch_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Front end of the single-issue RISC-V pipeline. Owns the program counter,
// presents it as a byte address to a combinational instruction memory, and
// captures the returned word into the IF/ID pipeline register.
//
// Update priority for both the PC and IF/ID on every clock edge:
//   branch_taken > stall > fetch_halted > normal sequential fetch
//
// Ports
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   stall             freeze PC and IF/ID (hazard unit)
//   branch_taken      redirect request; squashes the wrong-path fetch
//   branch_target     redirect byte address (low two bits are dropped)
//   inst_address      current PC to instruction memory
//   instruction       word returned combinationally for inst_address
//   if_id_valid       IF/ID holds a real instruction
//   if_id_pc          PC of the IF/ID instruction
//   if_id_pc_plus4    if_id_pc + 4
//   if_id_instruction fetched word, or NOP_INSTR for a bubble
//   fetch_halted      PC lies beyond the last populated word
//   fetch_count       valid instructions delivered into IF/ID (wraps)
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 88,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] inst_address,
    input  logic [31:0] instruction,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instruction,
    output logic        fetch_halted,
    output logic [31:0] fetch_count
);

    // Highest PC whose whole word still lies inside the memory.
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    logic [31:0] pc;
    logic [31:0] pc_plus4;

    assign pc_plus4     = pc + 32'd4;
    assign inst_address = pc;
    assign fetch_halted = (pc > LAST_PC);

    // Program counter. Halt is not sticky: a redirect always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (branch_taken) begin
            pc <= {branch_target[31:2], 2'b00};
        end else if (!stall && !fetch_halted) begin
            pc <= pc_plus4;
        end
    end

    // IF/ID pipeline register and delivered-instruction counter.
    // On a flush or halt bubble the pc fields still track the current PC;
    // they are informational only since valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid       <= 1'b0;
            if_id_instruction <= NOP_INSTR;
            if_id_pc          <= RESET_PC;
            if_id_pc_plus4    <= RESET_PC + 32'd4;
            fetch_count       <= 32'd0;
        end else if (branch_taken) begin
            if_id_valid       <= 1'b0;
            if_id_instruction <= NOP_INSTR;
            if_id_pc          <= pc;
            if_id_pc_plus4    <= pc_plus4;
        end else if (stall) begin
            // hold every IF/ID field
        end else if (fetch_halted) begin
            if_id_valid       <= 1'b0;
            if_id_instruction <= NOP_INSTR;
            if_id_pc          <= pc;
            if_id_pc_plus4    <= pc_plus4;
        end else begin
            if_id_valid       <= 1'b1;
            if_id_instruction <= instruction;
            if_id_pc          <= pc;
            if_id_pc_plus4    <= pc_plus4;
            fetch_count       <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed test-plan steps followed by a randomized stall/branch phase.
// Expected values come from a behavioural model of the fetch rules kept in
// this file, plus constants from the program image for the directed steps.
// Inputs are driven on the falling edge; outputs are sampled 1 ns after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam int          IMEM_BYTES = 88;
    localparam int          WORDS      = IMEM_BYTES / 4;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] inst_address;
    logic [31:0] instruction;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instruction;
    logic        fetch_halted;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    // Program image.
    logic [31:0] mem [WORDS];

    // Reference model state.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_ifpc;
    logic [31:0] m_ifpc4;
    logic [31:0] m_instr;
    logic [31:0] m_count;

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (IMEM_BYTES),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .inst_address      (inst_address),
        .instruction       (instruction),
        .if_id_valid       (if_id_valid),
        .if_id_pc          (if_id_pc),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_instruction (if_id_instruction),
        .fetch_halted      (fetch_halted),
        .fetch_count       (fetch_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory; out-of-range reads are don't-care.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr + 32'd3 < 32'(IMEM_BYTES)) return mem[addr[31:2]];
        return 32'hdead_beef;
    endfunction

    assign instruction = mem_word(inst_address);

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".inst_address"},  inst_address,             m_pc);
        chk({tag, ".fetch_halted"},  {31'd0, fetch_halted},    {31'd0, m_pc + 32'd3 >= 32'(IMEM_BYTES)});
        chk({tag, ".valid"},         {31'd0, if_id_valid},     {31'd0, m_valid});
        chk({tag, ".if_id_pc"},      if_id_pc,                 m_ifpc);
        chk({tag, ".if_id_pc4"},     if_id_pc_plus4,           m_ifpc4);
        chk({tag, ".if_id_instr"},   if_id_instruction,        m_instr);
        chk({tag, ".fetch_count"},   fetch_count,              m_count);
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_ifpc  = 32'h0;
        m_ifpc4 = 32'h4;
        m_instr = NOP;
        m_count = 32'h0;
    endtask

    // One clock edge: drive inputs (caller is at a falling edge), let the edge
    // happen, advance the model by the fetch rules, compare, then return at
    // the next falling edge.
    task automatic step(input logic s, input logic b, input logic [31:0] tgt, input string tag);
        logic out_of_range;
        stall         = s;
        branch_taken  = b;
        branch_target = tgt;
        @(posedge clk);
        #1;
        out_of_range = (m_pc + 32'd3 >= 32'(IMEM_BYTES));
        if (b) begin
            m_valid = 1'b0;
            m_instr = NOP;
            m_ifpc  = m_pc;
            m_ifpc4 = m_pc + 32'd4;
            m_pc    = tgt & ~32'd3;
        end else if (s) begin
            // everything holds
        end else if (out_of_range) begin
            m_valid = 1'b0;
            m_instr = NOP;
            m_ifpc  = m_pc;
            m_ifpc4 = m_pc + 32'd4;
        end else begin
            m_valid = 1'b1;
            m_instr = mem[m_pc >> 2];
            m_ifpc  = m_pc;
            m_ifpc4 = m_pc + 32'd4;
            m_count = m_count + 32'd1;
            m_pc    = m_pc + 32'd4;
        end
        check_model(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        #1;
        model_reset();
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[0]  = 32'h0014_0413;
        mem[1]  = 32'h0004_3903;
        mem[3]  = 32'h0080_0eb3;
        mem[8]  = 32'h02be_8663;
        mem[21] = 32'hfa00_0ae3;

        rst_n = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        @(negedge clk);
        do_reset();
        chk("reset.count_const", fetch_count, 32'd0);

        // Reset release: addresses 0, 4, 8.
        step(0, 0, 0, "edge1");
        chk("edge1.instr_const", if_id_instruction, 32'h0014_0413);
        chk("edge1.addr_const", inst_address, 32'd4);
        step(0, 0, 0, "edge2");
        chk("edge2.instr_const", if_id_instruction, 32'h0004_3903);
        step(0, 0, 0, "edge3");
        chk("edge3.addr_const", inst_address, 32'd12);

        // Stall for two edges at address 12.
        step(1, 0, 0, "stall1");
        step(1, 0, 0, "stall2");
        chk("stall.ifpc_const", if_id_pc, 32'd8);
        step(0, 0, 0, "unstall");
        chk("unstall.instr_const", if_id_instruction, 32'h0080_0eb3);

        // Run to address 60 then branch to 32.
        for (int i = 0; i < 20 && m_pc != 32'd60; i++) step(0, 0, 0, "seq60");
        chk("seq60.addr", inst_address, 32'd60);
        step(0, 1, 32'd32, "br32");
        chk("br32.instr_const", if_id_instruction, NOP);
        step(0, 0, 0, "br32_next");
        chk("br32_next.instr_const", if_id_instruction, 32'h02be_8663);

        // Branch and stall together, misaligned target.
        step(1, 1, 32'h22, "br_stall");
        chk("br_stall.addr_const", inst_address, 32'h20);

        // From reset, run sequentially to the end of memory.
        do_reset();
        for (int i = 0; i < 40 && m_pc <= 32'd84; i++) step(0, 0, 0, "seq_end");
        chk("halt.count_const", fetch_count, 32'd22);
        step(0, 0, 0, "halt1");
        step(0, 0, 0, "halt2");
        chk("halt.addr_const", inst_address, 32'd88);
        chk("halt.flag_const", {31'd0, fetch_halted}, 32'd1);
        step(0, 1, 32'd84, "halt_br84");
        step(0, 0, 0, "halt_br84_next");
        chk("br84.instr_const", if_id_instruction, 32'hfa00_0ae3);
        chk("br84.valid_const", {31'd0, if_id_valid}, 32'd1);

        // Randomized stall/branch traffic, including misaligned and
        // out-of-range targets.
        for (int i = 0; i < 400; i++) begin
            logic        s;
            logic        b;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = 32'($urandom_range(0, 100));
            step(s, b, t, "rand");
        end

        // Reach address 40 with a valid IF/ID, then reset mid-cycle.
        step(0, 1, 32'd36, "pre_rst_br");
        step(0, 0, 0, "pre_rst_fetch");
        chk("pre_rst.addr_const", inst_address, 32'd40);
        #2;
        do_reset();
        chk("mid_rst.valid_const", {31'd0, if_id_valid}, 32'd0);
        step(0, 0, 0, "resume1");
        chk("resume1.ifpc_const", if_id_pc, 32'd0);
        step(0, 0, 0, "resume2");
        step(0, 0, 0, "resume3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
